pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central hazard/sequencing controller for the 5-stage MIPS pipeline.
- Generates the PC write enable, the IF/ID write enable and flush, and the ID/EX bubble insert.
- Detects load-use hazards, taken-branch and jump control hazards, and multi-cycle MULT/DIV occupancy.
- Sits beside the IF/ID and ID/EX registers; takes ID-stage decode fields and EX-stage status.

Parameters:
- MD_CYCLES, 32, total EX occupancy of a mult/div in cycles; legal range 2..63.
- CNT_W, 6, width of the mult/div down-counter; must satisfy 2^CNT_W > MD_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_opcode  in  6  opcode of the instruction in ID.
- id_funct  in  6  funct field of the instruction in ID.
- id_rs  in  5  rs of the instruction in ID.
- id_rt  in  5  rt of the instruction in ID.
- ex_memread  in  1  the instruction in EX is a load.
- ex_rt  in  5  destination rt of the instruction in EX.
- ex_md_start  in  1  a mult/div entered EX this cycle (single-cycle pulse).
- ex_branch_taken  in  1  a branch resolved taken in EX this cycle.
- id_jump  in  1  the instruction in ID is j/jal/jr.
- pc_write  out  1  PC register load enable.
- if_id_write  out  1  IF/ID register load enable.
- if_flush  out  1  IF/ID load-zero (NOP) strobe.
- id_ex_bubble  out  1  forces ID/EX control fields to zero.
- md_busy  out  1  the mult/div unit is occupied.
- stall_cycles  out  32  count of cycles in which if_id_write=0.

Behaviour:
- States: RUN, MD_BUSY. Register md_cnt[CNT_W-1:0].
- Reset, and every cycle rst=1: state=RUN, md_cnt=0, stall_cycles=0. Outputs while rst=1: pc_write=0, if_id_write=0, if_flush=0, id_ex_bubble=1, md_busy=0.
- All enable/flush outputs are combinational from the state and the current inputs; zero-cycle latency to the pipeline registers.
- uses_rt: opcode 0x00, 0x04 (beq), 0x05 (bne) or 0x2B (sw).
- is_md: opcode 0x00 with funct 0x18-0x1B.
- is_hilo: opcode 0x00 with funct 0x10-0x13.
- load_use = ex_memread && ex_rt!=0 && (ex_rt==id_rs || (uses_rt && ex_rt==id_rt)).
- md_hazard = md_busy && (is_md || is_hilo).
- Priority, highest first:
  1. ex_branch_taken: pc_write=1, if_id_write=1, if_flush=1, id_ex_bubble=1. Overrides all stalls, because the ID instruction is wrong-path.
  2. load_use: pc_write=0, if_id_write=0, if_flush=0, id_ex_bubble=1.
  3. md_hazard: same outputs as load_use; held for as long as the hazard persists.
  4. id_jump: pc_write=1, if_id_write=1, if_flush=1, id_ex_bubble=0.
  5. Otherwise: pc_write=1, if_id_write=1, if_flush=0, id_ex_bubble=0.
- A jump in ID during a stall is held, not flushed, until the stall clears.
- FSM transitions:
  - RUN -> MD_BUSY on ex_md_start; md_cnt <= MD_CYCLES-2.
  - MD_BUSY: md_cnt decrements each cycle. At md_cnt==0 go to RUN.
  - ex_md_start while in MD_BUSY is a protocol error (prevented by md_hazard); if it occurs, reload md_cnt to MD_CYCLES-2.
  - md_busy = (state==MD_BUSY). A mult/div starting at cycle t keeps md_busy high for cycles t+1 .. t+MD_CYCLES-1.
- md_cnt never wraps below 0.
- A taken branch while in MD_BUSY does not cancel the mult/div: the instruction has already issued.
- stall_cycles increments by 1 in each non-reset cycle with if_id_write=0. It wraps modulo 2^32.

Decomposition:
- Shared package pipe_pkg holds:
  - opcode constants: OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_BNE=6'h05, OP_SW=6'h2B;
  - funct constants: FN_MFHI=6'h10, FN_MTHI=6'h11, FN_MFLO=6'h12, FN_MTLO=6'h13, FN_MULT=6'h18, FN_MULTU=6'h19, FN_DIV=6'h1A, FN_DIVU=6'h1B;
  - the state encoding localparams.
- One natural sub-module, hazard_decode: purely combinational, computes uses_rt, is_md, is_hilo and load_use.
- The FSM, counters and priority mux stay in pipe_hazard_ctrl.

Test Plan:
- Load-use: ex_memread=1, ex_rt=8, id_rs=8, id_opcode=0 -> exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles increments to 1. Repeat with ex_rt=0 -> no stall.
- Store rt dependency: id_opcode=0x2B, id_rt=9, id_rs=3, ex_memread=1, ex_rt=9 -> stall. Same with id_opcode=0x23 (lw, rt is a destination) -> no stall.
- Branch vs stall: ex_branch_taken=1 in the same cycle as load_use=1 -> pc_write=1, if_flush=1, id_ex_bubble=1, and stall_cycles unchanged.
- MULT/DIV with MD_CYCLES=4: pulse ex_md_start at cycle 0 -> md_busy high in cycles 1-3. An mflo (funct 0x12) in ID at cycle 1 is stalled in cycles 1-3 and issues at cycle 4; stall_cycles=3. An add (funct 0x20) in ID during the busy window -> no stall.
- Jump: id_jump=1 with no hazard -> if_flush=1, pc_write=1 for 1 cycle. id_jump=1 together with a load_use -> if_flush=0 and stall; if_flush=1 on the following cycle.
- Reset mid-operation: assert rst in cycle 2 of MD_BUSY -> the next cycle shows md_busy=0, stall_cycles=0, id_ex_bubble=1. After rst drops, the block is in RUN and pc_write=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared decode constants and FSM state encoding for the pipeline hazard controller.
package pipe_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   localparam logic [0:0] ST_RUN     = 1'b0;
   localparam logic [0:0] ST_MD_BUSY = 1'b1;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID/EX decode and status inputs plus pipeline control outputs of the hazard controller.
interface pipe_hazard_ctrl_if;
   logic [5:0]  id_opcode;
   logic [5:0]  id_funct;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        ex_memread;
   logic [4:0]  ex_rt;
   logic        ex_md_start;
   logic        ex_branch_taken;
   logic        id_jump;
   logic        pc_write;
   logic        if_id_write;
   logic        if_flush;
   logic        id_ex_bubble;
   logic        md_busy;
   logic [31:0] stall_cycles;

   modport master (
      output id_opcode, id_funct, id_rs, id_rt, ex_memread, ex_rt,
             ex_md_start, ex_branch_taken, id_jump,
      input  pc_write, if_id_write, if_flush, id_ex_bubble, md_busy, stall_cycles
   );

   modport slave (
      input  id_opcode, id_funct, id_rs, id_rt, ex_memread, ex_rt,
             ex_md_start, ex_branch_taken, id_jump,
      output pc_write, if_id_write, if_flush, id_ex_bubble, md_busy, stall_cycles
   );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_decode.sv
// Combinational ID-stage classification and load-use dependency detection.
module hazard_decode
   import pipe_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       ex_memread,
   input  logic [4:0] ex_rt,
   output logic       uses_rt,
   output logic       is_md,
   output logic       is_hilo,
   output logic       load_use
);

   always_comb begin
      uses_rt  = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                 (opcode == OP_BNE)   || (opcode == OP_SW);
      is_md    = (opcode == OP_RTYPE) &&
                 (funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
      is_hilo  = (opcode == OP_RTYPE) &&
                 (funct inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO});
      // $zero is never a real producer, so a load into r0 cannot cause a stall
      load_use = ex_memread && (ex_rt != 5'd0) &&
                 ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: stall, flush and bubble generation plus mult/div occupancy.
//  state      | meaning
//  ST_RUN     | mult/div unit idle, only load-use/branch/jump hazards apply
//  ST_MD_BUSY | mult/div occupying EX; md_cnt counts remaining busy cycles
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MD_CYCLES = 32,
   parameter int CNT_W     = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   pipe_hazard_ctrl_if.slave     hz
);

   localparam logic [CNT_W-1:0] MD_RELOAD = CNT_W'(MD_CYCLES - 2);

   logic [0:0]       state;
   logic [CNT_W-1:0] md_cnt;
   logic [31:0]      stall_cnt;
   logic             uses_rt;
   logic             is_md;
   logic             is_hilo;
   logic             load_use;
   logic             md_hazard;

   hazard_decode u_decode (
      .opcode     (hz.id_opcode),
      .funct      (hz.id_funct),
      .rs         (hz.id_rs),
      .rt         (hz.id_rt),
      .ex_memread (hz.ex_memread),
      .ex_rt      (hz.ex_rt),
      .uses_rt    (uses_rt),
      .is_md      (is_md),
      .is_hilo    (is_hilo),
      .load_use   (load_use)
   );

   assign md_hazard = (state == ST_MD_BUSY) && (is_md || is_hilo);

   always_comb begin
      hz.pc_write     = 1'b1;
      hz.if_id_write  = 1'b1;
      hz.if_flush     = 1'b0;
      hz.id_ex_bubble = 1'b0;
      hz.md_busy      = (state == ST_MD_BUSY) && !rst;
      if (rst) begin
         hz.pc_write     = 1'b0;
         hz.if_id_write  = 1'b0;
         hz.id_ex_bubble = 1'b1;
      end else if (hz.ex_branch_taken) begin
         // ID holds a wrong-path instruction, so any stall it raised is moot
         hz.if_flush     = 1'b1;
         hz.id_ex_bubble = 1'b1;
      end else if (load_use || md_hazard) begin
         hz.pc_write     = 1'b0;
         hz.if_id_write  = 1'b0;
         hz.id_ex_bubble = 1'b1;
      end else if (hz.id_jump) begin
         hz.if_flush     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_RUN;
         md_cnt <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (hz.ex_md_start) begin
                  state  <= ST_MD_BUSY;
                  md_cnt <= MD_RELOAD;
               end
            end
            ST_MD_BUSY: begin
               // a restart here is a protocol error; reloading keeps occupancy safe
               if (hz.ex_md_start)
                  md_cnt <= MD_RELOAD;
               else if (md_cnt == '0)
                  state <= ST_RUN;
               else
                  md_cnt <= md_cnt - 1'b1;
            end
            default: begin
               state  <= ST_RUN;
               md_cnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (!hz.if_id_write)
         stall_cnt <= stall_cnt + 32'd1;
   end

   assign hz.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with a 4-cycle mult/div.
module tb_pipe_hazard_ctrl;
   import pipe_pkg::*;

   // expected control vector order: {pc_write, if_id_write, if_flush, id_ex_bubble, md_busy}
   localparam logic [4:0] C_NORM  = 5'b11000;
   localparam logic [4:0] C_STALL = 5'b00010;
   localparam logic [4:0] C_BR    = 5'b11110;
   localparam logic [4:0] C_JMP   = 5'b11100;
   localparam logic [4:0] C_RST   = 5'b00010;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       mr;
      logic [4:0] ert;
      logic       mds;
      logic       br;
      logic       jmp;
      logic       rs_t;
      logic [4:0] ctl;
   } stim_t;

   typedef struct {
      logic [4:0]  ctl;
      logic [31:0] stall;
   } exp_t;

   logic clk;
   logic rst;
   pipe_hazard_ctrl_if hz ();

   pipe_hazard_ctrl #(.MD_CYCLES(4), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t        sb[$];
   logic [31:0] exp_stall;
   int          tests_run;
   int          tests_failed;

   function automatic stim_t mk(logic [5:0] op, logic [5:0] fn, logic [4:0] rs, logic [4:0] rt,
                                logic mr, logic [4:0] ert, logic mds, logic br, logic jmp,
                                logic r, logic [4:0] ctl);
      stim_t s;
      s.op = op; s.fn = fn; s.rs = rs; s.rt = rt; s.mr = mr; s.ert = ert;
      s.mds = mds; s.br = br; s.jmp = jmp; s.rs_t = r; s.ctl = ctl;
      return s;
   endfunction

   function automatic logic [4:0] obs();
      return {hz.pc_write, hz.if_id_write, hz.if_flush, hz.id_ex_bubble, hz.md_busy};
   endfunction

   // drive one cycle of stimulus and queue what the outputs must be in that cycle
   task automatic apply(input stim_t s);
      exp_t e;
      hz.id_opcode = s.op; hz.id_funct = s.fn; hz.id_rs = s.rs; hz.id_rt = s.rt;
      hz.ex_memread = s.mr; hz.ex_rt = s.ert; hz.ex_md_start = s.mds;
      hz.ex_branch_taken = s.br; hz.id_jump = s.jmp; rst = s.rs_t;
      e.ctl   = s.ctl;
      e.stall = exp_stall;
      sb.push_back(e);
      if (s.rs_t)
         exp_stall = 32'd0;
      else if (!s.ctl[3])
         exp_stall = exp_stall + 32'd1;
   endtask

   task automatic test_reset();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(6'h00, 6'h20, 5'd8, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, C_RST));
      t.push_back(mk(6'h00, 6'h20, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM));
      foreach (t[i]) begin
         apply(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         tests_run++;
         if ({obs(), hz.stall_cycles} !== {e.ctl, e.stall}) begin
            tests_failed++;
            $display("FAIL reset[%0d]: got ctl=%b stall=%0d, expected ctl=%b stall=%0d",
                     i, obs(), hz.stall_cycles, e.ctl, e.stall);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(6'h00, 6'h20, 5'd8, 5'd1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL));
      t.push_back(mk(6'h00, 6'h20, 5'd8, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM));
      t.push_back(mk(6'h00, 6'h20, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM));
      t.push_back(mk(6'h00, 6'h20, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL));
      t.push_back(mk(6'h00, 6'h20, 5'd3, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM));
      foreach (t[i]) begin
         apply(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         tests_run++;
         if ({obs(), hz.stall_cycles} !== {e.ctl, e.stall}) begin
            tests_failed++;
            $display("FAIL load_use[%0d]: got ctl=%b stall=%0d, expected ctl=%b stall=%0d",
                     i, obs(), hz.stall_cycles, e.ctl, e.stall);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_store_dep();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(6'h2B, 6'h00, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL));
      t.push_back(mk(6'h23, 6'h00, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM));
      t.push_back(mk(6'h04, 6'h00, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL));
      t.push_back(mk(6'h00, 6'h20, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM));
      foreach (t[i]) begin
         apply(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         tests_run++;
         if ({obs(), hz.stall_cycles} !== {e.ctl, e.stall}) begin
            tests_failed++;
            $display("FAIL store_dep[%0d]: got ctl=%b stall=%0d, expected ctl=%b stall=%0d",
                     i, obs(), hz.stall_cycles, e.ctl, e.stall);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch_vs_stall();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(6'h00, 6'h20, 5'd8, 5'd1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, C_BR));
      t.push_back(mk(6'h00, 6'h20, 5'd8, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM));
      foreach (t[i]) begin
         apply(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         tests_run++;
         if ({obs(), hz.stall_cycles} !== {e.ctl, e.stall}) begin
            tests_failed++;
            $display("FAIL branch_vs_stall[%0d]: got ctl=%b stall=%0d, expected ctl=%b stall=%0d",
                     i, obs(), hz.stall_cycles, e.ctl, e.stall);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mult_div();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(6'h00, 6'h20, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM));
      for (int k = 0; k < 3; k++)
         t.push_back(mk(6'h00, FN_MFLO, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL | 5'b00001));
      t.push_back(mk(6'h00, FN_MFLO, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM));
      // second op: independent add flows, and a taken branch does not cancel occupancy
      t.push_back(mk(6'h00, 6'h20, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM));
      t.push_back(mk(6'h00, 6'h20, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM | 5'b00001));
      t.push_back(mk(6'h00, FN_MULT, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_BR | 5'b00001));
      t.push_back(mk(6'h00, FN_DIV, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL | 5'b00001));
      t.push_back(mk(6'h00, FN_DIV, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM));
      foreach (t[i]) begin
         apply(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         tests_run++;
         if ({obs(), hz.stall_cycles} !== {e.ctl, e.stall}) begin
            tests_failed++;
            $display("FAIL mult_div[%0d]: got ctl=%b stall=%0d, expected ctl=%b stall=%0d",
                     i, obs(), hz.stall_cycles, e.ctl, e.stall);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_jump();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(6'h02, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_JMP));
      t.push_back(mk(6'h00, 6'h08, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, C_STALL));
      t.push_back(mk(6'h00, 6'h08, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_JMP));
      t.push_back(mk(6'h00, 6'h20, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM));
      foreach (t[i]) begin
         apply(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         tests_run++;
         if ({obs(), hz.stall_cycles} !== {e.ctl, e.stall}) begin
            tests_failed++;
            $display("FAIL jump[%0d]: got ctl=%b stall=%0d, expected ctl=%b stall=%0d",
                     i, obs(), hz.stall_cycles, e.ctl, e.stall);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk(6'h00, 6'h20, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM));
      t.push_back(mk(6'h00, FN_MFHI, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL | 5'b00001));
      t.push_back(mk(6'h00, FN_MFHI, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_RST));
      t.push_back(mk(6'h00, FN_MFHI, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM));
      t.push_back(mk(6'h00, FN_MTLO, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM));
      foreach (t[i]) begin
         apply(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         tests_run++;
         if ({obs(), hz.stall_cycles} !== {e.ctl, e.stall}) begin
            tests_failed++;
            $display("FAIL reset_mid[%0d]: got ctl=%b stall=%0d, expected ctl=%b stall=%0d",
                     i, obs(), hz.stall_cycles, e.ctl, e.stall);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      exp_stall    = 32'd0;
      rst = 1'b1;
      hz.id_opcode = '0; hz.id_funct = '0; hz.id_rs = '0; hz.id_rt = '0;
      hz.ex_memread = 1'b0; hz.ex_rt = '0; hz.ex_md_start = 1'b0;
      hz.ex_branch_taken = 1'b0; hz.id_jump = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      test_reset();
      test_load_use();
      test_store_dep();
      test_branch_vs_stall();
      test_mult_div();
      test_jump();
      test_reset_mid();
      if (sb.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
